// File: rtl/mem_wb_mux_sequencer_pkg.sv
// Shared definitions for the memory stage: op classes, sequencer states,
// one-hot select constants for the MEM/WB data input multiplexor.
package mem_stage_pkg;

  localparam logic [3:0] OP_PASS    = 4'd0;
  localparam logic [3:0] OP_LD8     = 4'd1;
  localparam logic [3:0] OP_LD16    = 4'd2;
  localparam logic [3:0] OP_SFR     = 4'd3;
  localparam logic [3:0] OP_CPY_WT  = 4'd4;
  localparam logic [3:0] OP_CPY_WB  = 4'd5;
  localparam logic [3:0] OP_SWP_TM1 = 4'd6;
  localparam logic [3:0] OP_DUP_TM1 = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SEL_TOP_NONE    = 4'b0000;
  localparam logic [3:0] SEL_TOP_EX_MEM  = 4'b0001;
  localparam logic [3:0] SEL_TOP_LD_RES  = 4'b0010;
  localparam logic [3:0] SEL_TOP_TM1_TOP = 4'b0100;
  localparam logic [3:0] SEL_TOP_TM1_BOT = 4'b1000;

  localparam logic [6:0] SEL_BOT_NONE    = 7'b0000000;
  localparam logic [6:0] SEL_BOT_SFR     = 7'b0000001;
  localparam logic [6:0] SEL_BOT_EX_MEM  = 7'b0000010;
  localparam logic [6:0] SEL_BOT_LD_RES  = 7'b0000100;
  localparam logic [6:0] SEL_BOT_WB_TOP  = 7'b0001000;
  localparam logic [6:0] SEL_BOT_WB_BOT  = 7'b0010000;
  localparam logic [6:0] SEL_BOT_TM1_TOP = 7'b0100000;
  localparam logic [6:0] SEL_BOT_TM1_BOT = 7'b1000000;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD8) || (op == OP_LD16);
  endfunction

endpackage

// File: rtl/mem_wb_mux_sequencer_if.sv
// Handshake and select bundle between the EX/MEM stage, data memory and the
// MEM/WB multiplexor control.
interface mem_wb_mux_sequencer_if;
  logic       ex_mem_valid;
  logic [3:0] ex_mem_op;
  logic       mem_ack;
  logic       mem_req;
  logic [3:0] sel_top;
  logic [6:0] sel_bot;
  logic       mem_wb_we;
  logic       stall;
  logic       bus_err;

  modport master (
    output ex_mem_valid, ex_mem_op, mem_ack,
    input  mem_req, sel_top, sel_bot, mem_wb_we, stall, bus_err
  );

  modport slave (
    input  ex_mem_valid, ex_mem_op, mem_ack,
    output mem_req, sel_top, sel_bot, mem_wb_we, stall, bus_err
  );
endinterface

// File: rtl/mem_wb_mux_sequencer_sel_decode.sv
// Combinational op-class decode into one-hot top/bottom selects; reserved
// op classes fall back to PASS.
module mem_wb_sel_decode
  import mem_stage_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] sel_top,
  output logic [6:0] sel_bot
);

  // Op class to select lookup
  always_comb begin
    sel_top = SEL_TOP_EX_MEM;
    sel_bot = SEL_BOT_EX_MEM;
    case (op)
      OP_PASS:    begin sel_top = SEL_TOP_EX_MEM;  sel_bot = SEL_BOT_EX_MEM;  end
      OP_LD8:     begin sel_top = SEL_TOP_EX_MEM;  sel_bot = SEL_BOT_LD_RES;  end
      OP_LD16:    begin sel_top = SEL_TOP_LD_RES;  sel_bot = SEL_BOT_LD_RES;  end
      OP_SFR:     begin sel_top = SEL_TOP_EX_MEM;  sel_bot = SEL_BOT_SFR;     end
      OP_CPY_WT:  begin sel_top = SEL_TOP_EX_MEM;  sel_bot = SEL_BOT_WB_TOP;  end
      OP_CPY_WB:  begin sel_top = SEL_TOP_EX_MEM;  sel_bot = SEL_BOT_WB_BOT;  end
      OP_SWP_TM1: begin sel_top = SEL_TOP_TM1_BOT; sel_bot = SEL_BOT_TM1_TOP; end
      OP_DUP_TM1: begin sel_top = SEL_TOP_TM1_TOP; sel_bot = SEL_BOT_TM1_BOT; end
      default:    begin sel_top = SEL_TOP_EX_MEM;  sel_bot = SEL_BOT_EX_MEM;  end
    endcase
  end

endmodule

// File: rtl/mem_wb_mux_sequencer.sv
// MEM/WB mux control: decodes op selects and sequences loads over req/ack,
// stalling the pipeline and inserting bubbles until load data is captured.
module mem_wb_mux_sequencer
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  mem_wb_mux_sequencer_if.slave  bus
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       held_op;
  logic [3:0]       dec_op;
  logic [3:0]       dec_top;
  logic [6:0]       dec_bot;
  logic             req;
  logic             stl;
  logic             we;
  logic             err;
  logic [3:0]       top;
  logic [6:0]       bot;

  mem_wb_sel_decode u_decode (
    .op      (dec_op),
    .sel_top (dec_top),
    .sel_bot (dec_bot)
  );

  // State, wait counter and held-op registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= {CNT_W{1'b0}};
      held_op  <= OP_PASS;
    end else begin
      state <= next_state;
      if (state == S_WAIT && next_state == S_WAIT) begin
        wait_cnt <= (wait_cnt == CNT_W'(MAX_WAIT)) ? wait_cnt : wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= {CNT_W{1'b0}};
      end
      if (state == S_IDLE && next_state == S_WAIT) begin
        held_op <= bus.ex_mem_op;
      end
    end
  end

  // Next state and output decode; DONE decodes the held op since EX/MEM may have moved on
  always_comb begin
    next_state = state;
    dec_op     = bus.ex_mem_op;
    req        = 1'b0;
    stl        = 1'b0;
    we         = 1'b0;
    err        = 1'b0;
    top        = SEL_TOP_NONE;
    bot        = SEL_BOT_NONE;
    case (state)
      S_IDLE: begin
        if (bus.ex_mem_valid) begin
          if (is_load(bus.ex_mem_op) && !bus.mem_ack) begin
            req        = 1'b1;
            stl        = 1'b1;
            next_state = S_WAIT;
          end else begin
            we  = 1'b1;
            top = dec_top;
            bot = dec_bot;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          req        = 1'b1;
          stl        = 1'b1;
          next_state = S_DONE;
        end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
          err        = 1'b1;
          next_state = S_IDLE;
        end else begin
          req        = 1'b1;
          stl        = 1'b1;
        end
      end
      S_DONE: begin
        dec_op     = held_op;
        we         = 1'b1;
        top        = dec_top;
        bot        = dec_bot;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held
  always_comb begin
    if (reset) begin
      bus.mem_req   = 1'b0;
      bus.stall     = 1'b0;
      bus.mem_wb_we = 1'b0;
      bus.bus_err   = 1'b0;
      bus.sel_top   = SEL_TOP_NONE;
      bus.sel_bot   = SEL_BOT_NONE;
    end else begin
      bus.mem_req   = req;
      bus.stall     = stl;
      bus.mem_wb_we = we;
      bus.bus_err   = err;
      bus.sel_top   = top;
      bus.sel_bot   = bot;
    end
  end

endmodule

// File: tb/tb_mem_wb_mux_sequencer.sv
// Directed literal checks plus randomized traffic compared every cycle
// against a transaction-level model of the load sequencer.
module tb_mem_wb_mux_sequencer;

  localparam int MAX_WAIT = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_wb_mux_sequencer_if bus ();

  mem_wb_mux_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Op table as bit positions of the one-hot selects
  int top_idx [8] = '{0, 0, 1, 0, 0, 0, 3, 2};
  int bot_idx [8] = '{1, 2, 2, 0, 3, 4, 5, 6};

  // Model: age of the outstanding load in cycles since issue (-1 none), done pending
  int         m_age  = -1;
  logic       m_done = 1'b0;
  logic [3:0] m_op   = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] tab_top(input logic [3:0] op);
    logic [3:0] o;
    o = 4'd1 << ((op > 4'd7) ? 0 : top_idx[op[2:0]]);
    return o;
  endfunction

  function automatic logic [6:0] tab_bot(input logic [3:0] op);
    logic [6:0] o;
    o = 7'd1 << ((op > 4'd7) ? 1 : bot_idx[op[2:0]]);
    return o;
  endfunction

  // Advance the model on each clock edge
  always @(posedge clock) begin
    if (reset) begin
      m_age  = -1;
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_age >= 0) begin
      if (bus.mem_ack) begin
        m_done = 1'b1;
        m_age  = -1;
      end else if (m_age == MAX_WAIT + 1) begin
        m_age = -1;
      end else begin
        m_age = m_age + 1;
      end
    end else if (bus.ex_mem_valid && (bus.ex_mem_op == 4'd1 || bus.ex_mem_op == 4'd2)
                 && !bus.mem_ack) begin
      m_age = 1;
      m_op  = bus.ex_mem_op;
    end
  end

  // Compare every output against the model on the falling edge
  always @(negedge clock) begin
    logic [3:0] e_top;
    logic [6:0] e_bot;
    logic       e_req, e_stall, e_we, e_err;
    e_top = 4'd0; e_bot = 7'd0; e_req = 1'b0; e_stall = 1'b0; e_we = 1'b0; e_err = 1'b0;
    if (!reset) begin
      if (m_done) begin
        e_top = tab_top(m_op); e_bot = tab_bot(m_op); e_we = 1'b1;
      end else if (m_age >= 0) begin
        if (!bus.mem_ack && m_age == MAX_WAIT + 1) e_err = 1'b1;
        else begin e_req = 1'b1; e_stall = 1'b1; end
      end else if (bus.ex_mem_valid) begin
        if ((bus.ex_mem_op == 4'd1 || bus.ex_mem_op == 4'd2) && !bus.mem_ack) begin
          e_req = 1'b1; e_stall = 1'b1;
        end else begin
          e_top = tab_top(bus.ex_mem_op); e_bot = tab_bot(bus.ex_mem_op); e_we = 1'b1;
        end
      end
    end
    chk("model_sel_top", 32'(bus.sel_top), 32'(e_top));
    chk("model_sel_bot", 32'(bus.sel_bot), 32'(e_bot));
    chk("model_req",     32'(bus.mem_req), 32'(e_req));
    chk("model_stall",   32'(bus.stall),   32'(e_stall));
    chk("model_we",      32'(bus.mem_wb_we), 32'(e_we));
    chk("model_bus_err", 32'(bus.bus_err), 32'(e_err));
  end

  // Drive one cycle of inputs just after the rising edge, then let outputs settle
  task automatic cyc(input logic v, input logic [3:0] op, input logic ack, input logic rst);
    @(posedge clock);
    #1;
    bus.ex_mem_valid = v;
    bus.ex_mem_op    = op;
    bus.mem_ack      = ack;
    reset            = rst;
    #2;
  endtask

  initial begin
    int stall_cnt;
    int err_cnt;
    int ack_pct;
    bus.ex_mem_valid = 1'b0;
    bus.ex_mem_op    = 4'd0;
    bus.mem_ack      = 1'b0;

    cyc(1'b1, 4'd0, 1'b1, 1'b1);
    chk("reset_outputs", {bus.sel_top, bus.sel_bot, bus.mem_req, bus.stall, bus.mem_wb_we, bus.bus_err}, 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);

    // Test 1 and 2: non-load ops and idle bubble
    cyc(1'b1, 4'd0, 1'b0, 1'b0);
    chk("pass_top", 32'(bus.sel_top), 32'h1);
    chk("pass_bot", 32'(bus.sel_bot), 32'h02);
    chk("pass_we_stall", {bus.mem_wb_we, bus.stall}, 32'h2);
    cyc(1'b1, 4'd6, 1'b0, 1'b0);
    chk("swp_top", 32'(bus.sel_top), 32'h8);
    chk("swp_bot", 32'(bus.sel_bot), 32'h20);
    cyc(1'b0, 4'd6, 1'b0, 1'b0);
    chk("invalid_sel_we", {bus.sel_top, bus.sel_bot, bus.mem_wb_we}, 32'd0);

    // Test 3: LD16 acked in cycle 3, data selected in cycle 4
    cyc(1'b1, 4'd2, 1'b0, 1'b0);
    chk("ld16_c0_req_stall", {bus.mem_req, bus.stall, bus.mem_wb_we}, 32'h6);
    cyc(1'b1, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'd7, 1'b0, 1'b0);
    chk("ld16_c2_req_stall", {bus.mem_req, bus.stall, bus.mem_wb_we}, 32'h6);
    cyc(1'b1, 4'd3, 1'b1, 1'b0);
    chk("ld16_ack_stall", {bus.mem_req, bus.stall, bus.mem_wb_we}, 32'h6);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("ld16_done_top", 32'(bus.sel_top), 32'h2);
    chk("ld16_done_bot", 32'(bus.sel_bot), 32'h04);
    chk("ld16_done_we", {bus.mem_req, bus.stall, bus.mem_wb_we}, 32'h1);

    // Test 4: zero-wait LD8
    cyc(1'b1, 4'd1, 1'b1, 1'b0);
    chk("ld8_zero_wait", {bus.sel_top, bus.sel_bot, bus.mem_wb_we, bus.stall}, {21'd0, 4'b0001, 7'b0000100, 1'b1, 1'b0});

    // Test 5: LD8 timeout
    stall_cnt = 0;
    err_cnt   = 0;
    cyc(1'b1, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (bus.stall && bus.mem_req) stall_cnt++;
      if (bus.bus_err) err_cnt++;
      cyc(1'b0, 4'd0, 1'b0, 1'b0);
    end
    chk("timeout_stall_cycles", 32'(stall_cnt), 32'd16);
    chk("timeout_bus_err_pulses", 32'(err_cnt), 32'd1);
    chk("after_timeout_we", 32'(bus.mem_wb_we), 32'd0);

    // Test 6: reset in the middle of a wait
    cyc(1'b1, 4'd1, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("mid_wait_reset", {bus.sel_top, bus.sel_bot, bus.mem_req, bus.stall, bus.mem_wb_we, bus.bus_err}, 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("after_reset_idle", {bus.sel_top, bus.sel_bot, bus.mem_req, bus.stall, bus.mem_wb_we, bus.bus_err}, 32'd0);
    cyc(1'b1, 4'd0, 1'b0, 1'b0);
    chk("after_reset_pass", {bus.sel_top, bus.sel_bot, bus.mem_wb_we, bus.stall}, {21'd0, 4'b0001, 7'b0000010, 1'b1, 1'b0});

    // Randomized traffic in phases of varying ack likelihood
    for (int ph = 0; ph < 12; ph++) begin
      ack_pct = (ph % 4 == 3) ? 0 : ((ph % 4 == 2) ? 4 : 35);
      for (int n = 0; n < 250; n++) begin
        logic [3:0] rop;
        rop = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 2)) : 4'($urandom_range(0, 15));
        cyc(($urandom_range(0, 3) != 0), rop,
            ($urandom_range(0, 99) < ack_pct), ($urandom_range(0, 199) == 0));
      end
    end
    cyc(1'b0, 4'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
